// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM burst controller.
//   ctrl_state_t : controller FSM state encoding, also exported on the
//                  controller's state_dbg port so checkers can bind to it.
package bram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_PRIME  = 3'd1,
        RD_STREAM = 3'd2,
        WR_STREAM = 3'd3,
        DONE      = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/bram_burst_ctrl.sv
// Burst controller in front of a single-port BRAM (masterBram).
// Accepts one read or write burst command at a time, range-checks it, then
// streams words between the BRAM port and a valid/ready data stream.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_len  burst direction, start address, length-1
//   wr_data/wr_valid/wr_ready     write-data stream into the block
//   rd_data/rd_valid/rd_ready     read-data stream out of the block
//   busy, done, err               status: not idle / burst complete / rejected
//   mem_wr, mem_address,
//   mem_data, mem_q               BRAM port (registered read address,
//                                 q valid one cycle after address)
//   state_dbg                     current FSM state
//
// Handshake rule for every stream: a transfer happens on a rising edge where
// valid and ready are both high; valid never depends on ready, and data is
// held stable by the source while valid is high and ready is low.
module bram_burst_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int MEMORY_DEPTH  = 4092,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [ADDRESS_WIDTH-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     mem_wr,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data,
    input  logic [DATA_WIDTH-1:0]    mem_q,
    output ctrl_state_t              state_dbg
);

    localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);

    ctrl_state_t              state, state_next;
    logic [ADDRESS_WIDTH-1:0] ptr;
    logic [ADDRESS_WIDTH-1:0] cnt;
    logic                     err_q;

    // Last address of the burst, one bit wider so the overflow is visible.
    logic [ADDRESS_WIDTH:0]   end_addr;
    logic                     cmd_ok;
    logic                     accept;
    logic                     beat;

    assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign cmd_ok   = (end_addr < DEPTH_EXT);
    assign accept   = (state == IDLE) && cmd_valid;
    assign beat     = ((state == RD_STREAM) && rd_ready) ||
                      ((state == WR_STREAM) && wr_valid);

    // State register and burst datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= accept && !cmd_ok;
            if (accept && cmd_ok) begin
                ptr <= cmd_addr;
                cnt <= cmd_len;
            end else if (beat && (cnt != '0)) begin
                // The final beat leaves ptr on the last address, so ptr
                // never steps beyond the end of the burst.
                ptr <= ptr + ADDRESS_WIDTH'(1);
                cnt <= cnt - ADDRESS_WIDTH'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && cmd_ok)
                    state_next = cmd_write ? WR_STREAM : RD_PRIME;
            end
            RD_PRIME:  state_next = RD_STREAM;
            RD_STREAM: if (rd_ready && (cnt == '0)) state_next = DONE;
            WR_STREAM: if (wr_valid && (cnt == '0)) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs. While rst is high everything is forced to its idle value so
    // an aborted burst cannot write or signal completion in the reset cycle.
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        wr_ready    = 1'b0;
        rd_valid    = 1'b0;
        mem_wr      = 1'b0;
        mem_address = ptr;
        mem_data    = wr_data;
        rd_data     = mem_q;
        if (rst) begin
            cmd_ready = 1'b1;
        end else begin
            case (state)
                IDLE:     cmd_ready = 1'b1;
                RD_PRIME: busy = 1'b1;
                RD_STREAM: begin
                    busy     = 1'b1;
                    rd_valid = 1'b1;
                    // Fetch the next word one cycle ahead only when the
                    // current one is consumed; otherwise re-read ptr so
                    // mem_q (and rd_data) holds under backpressure.
                    if (rd_ready && (cnt != '0))
                        mem_address = ptr + ADDRESS_WIDTH'(1);
                end
                WR_STREAM: begin
                    busy     = 1'b1;
                    wr_ready = 1'b1;
                    mem_wr   = wr_valid;
                end
                DONE: begin
                    busy = 1'b1;
                    done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign err       = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// Testbench for bram_burst_ctrl: cycle tables for the basic write/read and
// range-check bursts, plus hand-written sequences for read backpressure,
// reset mid-burst and a command held valid across a burst.
module tb_bram_burst_ctrl;
    import bram_ctrl_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    // {cmd_ready, busy, done, err, mem_wr, rd_valid, wr_ready}
    localparam logic [6:0] IDLE_C = 7'b1000000;
    localparam logic [6:0] ERR_C  = 7'b1001000;
    localparam logic [6:0] WRS_C  = 7'b0100101;
    localparam logic [6:0] DONE_C = 7'b0110000;
    localparam logic [6:0] PRI_C  = 7'b0100000;
    localparam logic [6:0] RDS_C  = 7'b0100010;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready = 1'b0;
    logic          busy, done, err, mem_wr;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data, mem_q;
    ctrl_state_t   state_dbg;

    bram_burst_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .err(err),
        .mem_wr(mem_wr), .mem_address(mem_address), .mem_data(mem_data),
        .mem_q(mem_q), .state_dbg(state_dbg)
    );

    // masterBram model: registered read address, not captured on writes.
    logic [DW-1:0] mem [0:4095];
    logic [AW-1:0] rd_addr_q = '0;
    always @(posedge clk) begin
        if (mem_wr) mem[mem_address] <= mem_data;
        else        rd_addr_q <= mem_address;
    end
    assign mem_q = mem[rd_addr_q];

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {cmd_ready, busy, done, err, mem_wr, rd_valid, wr_ready};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    endtask

    task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          cv;
        logic          cw;
        logic [AW-1:0] ca;
        logic [AW-1:0] cl;
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic [6:0]    ctrl;
        logic          chk_addr;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(logic cv, logic cw, logic [AW-1:0] ca, logic [AW-1:0] cl,
                                logic wv, logic [DW-1:0] wd, logic rr, logic [6:0] ctrl,
                                logic chk_addr, logic [AW-1:0] addr, logic [DW-1:0] rdata);
        vec_t v;
        v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd; v.rr = rr;
        v.ctrl = ctrl; v.chk_addr = chk_addr; v.addr = addr; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        logic pat [7];
        int   k;
        int   acc_n;
        int   acc_at [2];
        logic seen_done;
        string nm;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // write 0x010 len 3, read it back, then range checks at the top end
        vecs[0]  = mk(1, 1, 12'h010, 3, 0, 16'h0,    0, IDLE_C, 0, 12'h0,   16'h0);
        vecs[1]  = mk(0, 0, 12'h0,   0, 1, 16'hA000, 0, WRS_C,  1, 12'h010, 16'h0);
        vecs[2]  = mk(0, 0, 12'h0,   0, 1, 16'hA001, 0, WRS_C,  1, 12'h011, 16'h0);
        vecs[3]  = mk(0, 0, 12'h0,   0, 1, 16'hA002, 0, WRS_C,  1, 12'h012, 16'h0);
        vecs[4]  = mk(0, 0, 12'h0,   0, 1, 16'hA003, 0, WRS_C,  1, 12'h013, 16'h0);
        vecs[5]  = mk(0, 0, 12'h0,   0, 0, 16'h0,    0, DONE_C, 0, 12'h0,   16'h0);
        vecs[6]  = mk(1, 0, 12'h010, 3, 0, 16'h0,    1, IDLE_C, 0, 12'h0,   16'h0);
        vecs[7]  = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, PRI_C,  1, 12'h010, 16'h0);
        vecs[8]  = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, RDS_C,  1, 12'h011, 16'hA000);
        vecs[9]  = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, RDS_C,  1, 12'h012, 16'hA001);
        vecs[10] = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, RDS_C,  1, 12'h013, 16'hA002);
        vecs[11] = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, RDS_C,  1, 12'h013, 16'hA003);
        vecs[12] = mk(0, 0, 12'h0,   0, 0, 16'h0,    0, DONE_C, 0, 12'h0,   16'h0);
        vecs[13] = mk(1, 1, 12'd4090, 2, 0, 16'h0,   0, IDLE_C, 0, 12'h0,   16'h0);
        vecs[14] = mk(0, 0, 12'h0,   0, 0, 16'h0,    0, ERR_C,  0, 12'h0,   16'h0);
        vecs[15] = mk(1, 1, 12'd4089, 2, 0, 16'h0,   0, IDLE_C, 0, 12'h0,   16'h0);
        vecs[16] = mk(0, 0, 12'h0,   0, 1, 16'hB001, 0, WRS_C,  1, 12'd4089, 16'h0);
        vecs[17] = mk(0, 0, 12'h0,   0, 1, 16'hB002, 0, WRS_C,  1, 12'd4090, 16'h0);
        vecs[18] = mk(0, 0, 12'h0,   0, 1, 16'hB003, 0, WRS_C,  1, 12'd4091, 16'h0);
        vecs[19] = mk(0, 0, 12'h0,   0, 0, 16'h0,    0, DONE_C, 0, 12'h0,   16'h0);
        vecs[20] = mk(1, 0, 12'd4089, 2, 0, 16'h0,   1, IDLE_C, 0, 12'h0,   16'h0);
        vecs[21] = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, PRI_C,  1, 12'd4089, 16'h0);
        vecs[22] = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, RDS_C,  1, 12'd4090, 16'hB001);
        vecs[23] = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, RDS_C,  1, 12'd4091, 16'hB002);
        vecs[24] = mk(0, 0, 12'h0,   0, 0, 16'h0,    1, RDS_C,  1, 12'd4091, 16'hB003);
        vecs[25] = mk(0, 0, 12'h0,   0, 0, 16'h0,    0, DONE_C, 0, 12'h0,   16'h0);
        vecs[26] = mk(0, 0, 12'h0,   0, 0, 16'h0,    0, IDLE_C, 0, 12'h0,   16'h0);

        // ---- reset state ----
        drive_idle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("reset ctrl", ctrl_now(), IDLE_C);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post-reset ctrl", ctrl_now(), IDLE_C);

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw;
            cmd_addr  = vecs[i].ca; cmd_len   = vecs[i].cl;
            wr_valid  = vecs[i].wv; wr_data   = vecs[i].wd;
            rd_ready  = vecs[i].rr;
            @(negedge clk);
            nm = $sformatf("row%0d ctrl", i);
            check(nm, ctrl_now(), vecs[i].ctrl);
            if (vecs[i].chk_addr) begin
                nm = $sformatf("row%0d addr", i);
                check(nm, mem_address, vecs[i].addr);
            end
            if (vecs[i].ctrl[2]) begin
                nm = $sformatf("row%0d wdata", i);
                check(nm, mem_data, vecs[i].wd);
            end
            if (vecs[i].ctrl[1]) begin
                nm = $sformatf("row%0d rdata", i);
                check(nm, rd_data, vecs[i].rdata);
            end
        end

        // ---- read with backpressure 1,0,0,1,1,0,1 ----
        exp_q = {16'hA000, 16'hA001, 16'hA002, 16'hA003};
        next_cycle();
        drive_idle();
        drive_cmd(1'b0, 12'h010, 12'd3);
        @(negedge clk);
        check("bp accept", cmd_ready, 1'b1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        check("bp prime", ctrl_now(), PRI_C);
        k = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 30 && !seen_done; c++) begin
            next_cycle();
            rd_ready = (k < 7) ? pat[k] : 1'b1;
            @(negedge clk);
            if (done) begin
                seen_done = 1'b1;
            end else if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("bp extra word", 1'b1, 1'b0);
                end else begin
                    check("bp word", rd_data, exp_q[0]);
                    if (rd_ready) void'(exp_q.pop_front());
                end
                k++;
            end
        end
        check("bp done seen", seen_done, 1'b1);
        check("bp words left", exp_q.size(), 0);
        check("bp stream cycles", k, 7);

        // ---- reset during the 2nd word of a 4-word write ----
        next_cycle();
        drive_idle();
        drive_cmd(1'b1, 12'h020, 12'd3);
        @(negedge clk);
        check("rst accept", ctrl_now(), IDLE_C);
        next_cycle();
        drive_idle();
        wr_valid = 1'b1; wr_data = 16'hC000;
        @(negedge clk);
        check("rst word0", ctrl_now(), WRS_C);
        check("rst word0 addr", mem_address, 12'h020);
        next_cycle();
        rst = 1'b1; wr_data = 16'hC001;
        @(negedge clk);
        check("rst cycle ctrl", ctrl_now(), IDLE_C);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst after ctrl", ctrl_now(), IDLE_C);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            wr_valid = 1'b0;
            @(negedge clk);
            check("rst no done", ctrl_now(), IDLE_C);
        end

        // ---- cmd_valid held through a whole burst plus one cycle ----
        acc_n = 0;
        acc_at[0] = -1;
        acc_at[1] = -1;
        next_cycle();
        drive_cmd(1'b1, 12'h030, 12'd1);
        wr_valid = 1'b1; wr_data = 16'hD000;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                if (acc_n < 2) acc_at[acc_n] = c;
                acc_n++;
            end
        end
        check("held accepts", acc_n, 2);
        check("held first at", acc_at[0], 0);
        check("held second at", acc_at[1], 4);
        next_cycle();
        cmd_valid = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 10 && !seen_done; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            else next_cycle();
        end
        check("held second done", seen_done, 1'b1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        check("final idle", ctrl_now(), IDLE_C);

        // ---- final report ----
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
